// File: rtl/pu_play_sequencer.sv
// Board-level exerciser for a wr/sel/oe processor unit: steps operand pairs through
// write-A / write-B / wait / read and shows a result byte. Optional self-check: PU_PLAY_SELF_CHECK_EN.
module pu_play_sequencer #(
   parameter int DATA_WIDTH     = 32,
   parameter int ATTR_WIDTH     = 4,
   parameter int INVALID        = 1,
   parameter int LED_WIDTH      = 8,
   parameter int PRESCALE_WIDTH = 24,
   parameter int RESULT_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic                  step,
   input  logic                  speed_up,
   input  logic                  sel_reverse,
   output logic                  pu_signal_wr,
   output logic                  pu_signal_sel,
   output logic                  pu_signal_oe,
   output logic [DATA_WIDTH-1:0] pu_data_in,
   output logic [ATTR_WIDTH-1:0] pu_attr_in,
   input  logic [DATA_WIDTH-1:0] pu_data_out,
   input  logic [ATTR_WIDTH-1:0] pu_attr_out,
   output logic [LED_WIDTH-1:0]  led,
   output logic                  busy,
   output logic [15:0]           pass_cnt,
   output logic                  error
);

   localparam int H      = DATA_WIDTH / 2;
   localparam int WAIT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (RESULT_LATENCY > 0) ? WAIT_W'(RESULT_LATENCY - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_A,
      S_WR_B,
      S_WAIT,
      S_RD,
      S_SHOW
   } state_t;

   function automatic logic [LED_WIDTH-1:0] led_pick(input logic [DATA_WIDTH-1:0] r,
                                                     input logic                  hi);
      return hi ? r[DATA_WIDTH-1 -: LED_WIDTH] : r[LED_WIDTH-1:0];
   endfunction

   state_t                  state_q, state_d;
   logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic [H-1:0]            cnt_q, cnt_d;
   logic [H-1:0]            cnt_plus1;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic [2:0]              step_sync_q, step_sync_d;
   logic                    wr_q, wr_d;
   logic                    sel_q, sel_d;
   logic                    oe_q, oe_d;
   logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
   logic [ATTR_WIDTH-1:0]   attr_in_q, attr_in_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic [LED_WIDTH-1:0]    led_q, led_d;
   logic [15:0]             pass_q, pass_d;
   logic [DATA_WIDTH-1:0]   op_a, op_b;
   logic                    step_pulse;
   logic                    tick;
   logic                    trigger;
   logic                    err_flag;
   logic                    count_ok;
   logic                    unused_bits;

   assign cnt_plus1  = cnt_q + 1'b1;
   assign op_a       = {{(DATA_WIDTH-H){1'b0}}, cnt_q};
   assign op_b       = {{(DATA_WIDTH-H){1'b0}}, cnt_plus1};
   assign step_pulse = step_sync_q[1] & ~step_sync_q[2];
   assign tick       = (&prescale_q) |
                       (speed_up & (&prescale_q[PRESCALE_WIDTH-5:0]));
   assign trigger    = mode ? tick : step_pulse;

   // Sequencer: strobes are registered from the next state, so they line up with the state.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_IDLE: if (trigger) state_d = S_WR_A;
         S_WR_A: state_d = S_WR_B;
         S_WR_B: begin
            wait_cnt_d = '0;
            state_d    = (RESULT_LATENCY == 0) ? S_RD : S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) state_d = S_RD;
            else                         wait_cnt_d = wait_cnt_q + 1'b1;
         end
         S_RD:    state_d = S_SHOW;
         S_SHOW:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_d        = (state_d == S_WR_A) || (state_d == S_WR_B);
      sel_d       = (state_d == S_WR_B);
      oe_d        = (state_d == S_RD);
      data_in_d   = data_in_q;
      attr_in_d   = attr_in_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      pass_d      = pass_q;
      prescale_d  = prescale_q + 1'b1;
      step_sync_d = {step_sync_q[1:0], step};
      if (state_d == S_WR_A) begin
         data_in_d = op_a;
         attr_in_d = op_a[ATTR_WIDTH-1:0];
      end else if (state_d == S_WR_B) begin
         data_in_d = op_b;
         attr_in_d = op_a[ATTR_WIDTH-1:0];
      end
      if (state_q == S_RD) result_d = pu_data_out;
      if (state_q == S_SHOW) begin
         cnt_d = cnt_plus1;
         if (count_ok) pass_d = pass_q + 1'b1;
      end
      // An error forces the display to all-ones so a failure is visible at a glance.
      led_d = err_flag ? '1 : led_pick(result_q, sel_reverse);
   end

`ifdef PU_PLAY_SELF_CHECK_EN
   logic [DATA_WIDTH-1:0] ref_prod;
   logic                  match_q, match_d;
   logic                  error_q, error_d;

   assign ref_prod = op_a * op_b;

   always_comb begin
      match_d = match_q;
      error_d = error_q;
      if (state_q == S_RD) begin
         match_d = (pu_data_out == ref_prod) && !pu_attr_out[INVALID];
         error_d = error_q | ~match_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         match_q <= match_d;
         error_q <= error_d;
      end
   end

   assign err_flag = error_q;
   assign count_ok = match_q;
`else
   assign err_flag = 1'b0;
   assign count_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= '0;
         cnt_q       <= '0;
         prescale_q  <= '0;
         step_sync_q <= '0;
         wr_q        <= 1'b0;
         sel_q       <= 1'b0;
         oe_q        <= 1'b0;
         data_in_q   <= '0;
         attr_in_q   <= '0;
         result_q    <= '0;
         led_q       <= '0;
         pass_q      <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         cnt_q       <= cnt_d;
         prescale_q  <= prescale_d;
         step_sync_q <= step_sync_d;
         wr_q        <= wr_d;
         sel_q       <= sel_d;
         oe_q        <= oe_d;
         data_in_q   <= data_in_d;
         attr_in_q   <= attr_in_d;
         result_q    <= result_d;
         led_q       <= led_d;
         pass_q      <= pass_d;
      end
   end

   // Result bits between the two displayable bytes, and attributes, are captured but not shown.
   assign unused_bits = ^{pu_attr_out, result_q};

   assign pu_signal_wr  = wr_q;
   assign pu_signal_sel = sel_q;
   assign pu_signal_oe  = oe_q;
   assign pu_data_in    = data_in_q;
   assign pu_attr_in    = attr_in_q;
   assign led           = led_q;
   assign busy          = (state_q != S_IDLE);
   assign pass_cnt      = pass_q;
   assign error         = err_flag;

endmodule

// File: tb/tb_pu_play_sequencer.sv
// Scoreboard bench for pu_play_sequencer with a multiplier stub PU (16-bit data, 8-bit prescaler).
module tb_pu_play_sequencer;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int LW = 8;
   localparam int PW = 8;
   localparam int RL = 2;
   localparam int H  = DW / 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic mode = 1'b0, step = 1'b0, speed_up = 1'b0, sel_reverse = 1'b0;
   logic wr, sel, oe, busy, error;
   logic [DW-1:0] pu_data_in, pu_data_out;
   logic [AW-1:0] pu_attr_in, pu_attr_out;
   logic [LW-1:0] led;
   logic [15:0]   pass_cnt;

   pu_play_sequencer #(
      .DATA_WIDTH(DW), .ATTR_WIDTH(AW), .INVALID(1), .LED_WIDTH(LW),
      .PRESCALE_WIDTH(PW), .RESULT_LATENCY(RL)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .step(step), .speed_up(speed_up),
      .sel_reverse(sel_reverse), .pu_signal_wr(wr), .pu_signal_sel(sel),
      .pu_signal_oe(oe), .pu_data_in(pu_data_in), .pu_attr_in(pu_attr_in),
      .pu_data_out(pu_data_out), .pu_attr_out(pu_attr_out), .led(led),
      .busy(busy), .pass_cnt(pass_cnt), .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stub PU: latches operands on writes, returns A*B; the third read is corrupted by +1.
   logic [DW-1:0] stub_a = '0, stub_b = '0, stub_prod;
   int rd_idx = 0;
   always @(posedge clk) begin
      if (wr) begin
         if (sel) stub_b <= pu_data_in;
         else     stub_a <= pu_data_in;
      end
      if (oe) rd_idx <= rd_idx + 1;
   end
   assign stub_prod   = stub_a * stub_b;
   assign pu_data_out = stub_prod + ((rd_idx == 2) ? 16'd1 : 16'd0);
   assign pu_attr_out = '0;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   typedef struct { logic s; logic [DW-1:0] d; logic [AW-1:0] a; } wr_t;
   typedef struct { logic [LW-1:0] l; logic [15:0] p; logic e; } res_t;
   wr_t  wr_q[$];
   res_t res_q[$];

   logic [H-1:0] cnt_m  = '0;
   logic [15:0]  pass_m = '0;
   logic         err_m  = 1'b0;
   int           txn_m  = 0;

   task automatic push_writes();
      logic [H-1:0] nx;
      nx = cnt_m + 1'b1;
      wr_q.push_back('{1'b0, {{(DW-H){1'b0}}, cnt_m}, cnt_m[AW-1:0]});
      wr_q.push_back('{1'b1, {{(DW-H){1'b0}}, nx}, cnt_m[AW-1:0]});
   endtask

   task automatic push_result();
      logic [H-1:0]  nx;
      logic [DW-1:0] a, b, prod, got;
      logic [LW-1:0] l;
      nx   = cnt_m + 1'b1;
      a    = {{(DW-H){1'b0}}, cnt_m};
      b    = {{(DW-H){1'b0}}, nx};
      prod = a * b;
      got  = prod + ((txn_m == 2) ? 16'd1 : 16'd0);
`ifdef PU_PLAY_SELF_CHECK_EN
      if (got != prod) err_m = 1'b1;
      else             pass_m = pass_m + 1'b1;
`else
      pass_m = pass_m + 1'b1;
`endif
      l = err_m ? 8'hFF : (sel_reverse ? got[DW-1:DW-LW] : got[LW-1:0]);
      res_q.push_back('{l, pass_m, err_m});
      cnt_m = nx;
      txn_m++;
   endtask

   // Monitor: checks every write, every read timing, and each completed transaction.
   int   busy_len = 0, since_wr = 0;
   logic prev_busy = 1'b0;
   logic [DW-1:0] last_b = '0;
   always @(negedge clk) begin
      if (!rst) begin
         busy_len  = 0;
         since_wr  = 0;
         prev_busy = 1'b0;
      end else begin
         if (wr || oe) check("wr_oe_excl", {31'd0, wr & oe}, 32'd0);
         if (wr) begin
            if (wr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write actual=%0h required=none", pu_data_in);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               check("wr_sel", {31'd0, sel}, {31'd0, w.s});
               check("wr_data", {16'd0, pu_data_in}, {16'd0, w.d});
               check("wr_attr", {28'd0, pu_attr_in}, {28'd0, w.a});
               if (w.s) last_b = w.d;
            end
            since_wr = 0;
         end else begin
            if (oe) begin
               check("oe_delay", since_wr, RL);
               check("data_hold", {16'd0, pu_data_in}, {16'd0, last_b});
            end
            since_wr++;
         end
         if (busy) busy_len++;
         else if (prev_busy) begin
            check("busy_len", busy_len, 4 + RL);
            if (res_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_result actual=%0h required=none", led);
            end else begin
               res_t r;
               r = res_q.pop_front();
               check("led", {24'd0, led}, {24'd0, r.l});
               check("pass_cnt", {16'd0, pass_cnt}, {16'd0, r.p});
               check("error", {31'd0, error}, {31'd0, r.e});
            end
            busy_len = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic step_once();
      @(negedge clk) step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic txn_manual();
      push_writes();
      push_result();
      step_once();
   endtask

   task automatic wait_busy(input logic lvl, input int limit, output int t);
      int n;
      n = 0;
      while (busy !== lvl && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) begin
         total++; bad++;
         $display("FAIL wait_busy timeout actual=%0b required=%0b", busy, lvl);
      end
      t = cyc;
   endtask

   initial begin
      int t1, t2, t3, t4, tx;
      repeat (2) @(negedge clk);
      check("rst_wr", {31'd0, wr}, 32'd0);
      check("rst_sel", {31'd0, sel}, 32'd0);
      check("rst_oe", {31'd0, oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_led", {24'd0, led}, 32'd0);
      check("rst_pass", {16'd0, pass_cnt}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_data", {16'd0, pu_data_in}, 32'd0);
      check("rst_attr", {28'd0, pu_attr_in}, 32'd0);
      @(negedge clk) rst = 1'b1;

      for (int i = 0; i < 3; i++) txn_manual();
      check("err_after_bad", {31'd0, error}, {31'd0, err_m});

      for (int i = 3; i < 8'hFE; i++) txn_manual();
      txn_manual();
      @(negedge clk) sel_reverse = 1'b1;
      @(negedge clk);
      check("led_sel_rev", {24'd0, led}, err_m ? 32'hFF : 32'hFD);
      txn_manual();
      sel_reverse = 1'b0;
      txn_manual();
      check("err_after_wrap", {31'd0, error}, {31'd0, err_m});

      push_writes();
      push_result();
      @(negedge clk) step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      @(negedge clk) step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      repeat (20) @(negedge clk);
      check("drop_step_pass", {16'd0, pass_cnt}, {16'd0, pass_m});

      push_writes(); push_result();
      mode = 1'b1;
      wait_busy(1'b1, 600, t1);
      wait_busy(1'b0, 20, tx);
      push_writes(); push_result();
      wait_busy(1'b1, 600, t2);
      check("period_slow", t2 - t1, 256);
      wait_busy(1'b0, 20, tx);
      speed_up = 1'b1;
      push_writes(); push_result();
      wait_busy(1'b1, 40, t3);
      wait_busy(1'b0, 20, tx);
      push_writes(); push_result();
      wait_busy(1'b1, 40, t4);
      check("period_fast", t4 - t3, 16);
      mode = 1'b0;
      wait_busy(1'b0, 20, tx);
      repeat (40) @(negedge clk);
      check("mode_switch_pass", {16'd0, pass_cnt}, {16'd0, pass_m});

      push_writes();
      @(negedge clk) step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      wait_busy(1'b1, 20, tx);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("arst_wr", {31'd0, wr}, 32'd0);
      check("arst_sel", {31'd0, sel}, 32'd0);
      check("arst_oe", {31'd0, oe}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_led", {24'd0, led}, 32'd0);
      check("arst_pass", {16'd0, pass_cnt}, 32'd0);
      cnt_m  = '0;
      pass_m = '0;
      err_m  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      txn_manual();

      check("wr_queue_empty", wr_q.size(), 0);
      check("res_queue_empty", res_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
